// File: rtl/multiplicand_shift_reg.sv
// Multiplicand register for a sequential shift-add multiplier.
// A WIDTH-bit operand is loaded, zero- or sign-extended, into a 2*WIDTH-bit register.
// The register then shifts left one bit per step while a counter tracks the shifts.
// The block presents the register value, or its two's complement, as the adder operand.
//
// Ports:
//   clk                 clock, rising edge
//   rst                 active-low synchronous reset
//   clr                 active-high synchronous clear of register, counter and FSM
//   in_valid/in_ready   load handshake for multiplicand_input
//   multiplicand_input  WIDTH-bit operand
//   signed_mode         sampled at the load edge, 1 = sign-extend (if SIGNED_EN)
//   shift_en            request one left shift (honoured only while active)
//   negate              select two's-complement addend
//   multiplicand_output current register value
//   addend_output       negate ? -reg : reg, combinational
//   shift_count         shifts since the last load, saturates at WIDTH
//   done                WIDTH shifts completed
module multiplicand_shift_reg #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1,
  localparam int unsigned CW       = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand_input,
  input  logic               signed_mode,
  input  logic               shift_en,
  input  logic               negate,
  output logic [2*WIDTH-1:0] multiplicand_output,
  output logic [2*WIDTH-1:0] addend_output,
  output logic [CW-1:0]      shift_count,
  output logic               done
);

  localparam int unsigned DW = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] reg_q, reg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load;
  logic          ext_bit;
  logic [CW-1:0] cnt_inc;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      reg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign load    = in_valid && in_ready;
  assign ext_bit = SIGNED_EN && signed_mode && multiplicand_input[WIDTH-1];
  assign cnt_inc = cnt_q + CW'(1);

  // Next-state: clr beats load, load beats shift (so a load in StDone suppresses the shift)
  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = StIdle;
      reg_d   = '0;
      cnt_d   = '0;
    end else if (load) begin
      state_d = StActive;
      reg_d   = {{WIDTH{ext_bit}}, multiplicand_input};
      cnt_d   = '0;
    end else if (state_q == StActive && shift_en) begin
      reg_d = {reg_q[DW-2:0], 1'b0};
      cnt_d = cnt_inc;
      if (cnt_inc == CW'(WIDTH)) begin
        state_d = StDone;
      end
    end
  end

  // Outputs
  always_comb begin
    in_ready            = (state_q != StActive);
    done                = (state_q == StDone);
    multiplicand_output = reg_q;
    shift_count         = cnt_q;
    // Wraps modulo 2^DW: -0 = 0 and -2^(DW-1) = 2^(DW-1)
    addend_output       = negate ? (~reg_q + DW'(1)) : reg_q;
  end

endmodule

// File: tb/tb_multiplicand_shift_reg.sv
module tb_multiplicand_shift_reg;

  localparam int unsigned W  = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst, clr, in_valid, signed_mode, shift_en, negate;
  logic [W-1:0]  mi;
  logic          rdy, dn, rdy2, dn2;
  logic [DW-1:0] mo, ad, mo2, ad2;
  logic [CW-1:0] cnt, cnt2;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  multiplicand_shift_reg #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut (
    .clk                (clk),
    .rst                (rst),
    .clr                (clr),
    .in_valid           (in_valid),
    .in_ready           (rdy),
    .multiplicand_input (mi),
    .signed_mode        (signed_mode),
    .shift_en           (shift_en),
    .negate             (negate),
    .multiplicand_output(mo),
    .addend_output      (ad),
    .shift_count        (cnt),
    .done               (dn)
  );

  // Same stimulus, signed_mode disabled by parameter
  multiplicand_shift_reg #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_unsigned (
    .clk                (clk),
    .rst                (rst),
    .clr                (clr),
    .in_valid           (in_valid),
    .in_ready           (rdy2),
    .multiplicand_input (mi),
    .signed_mode        (signed_mode),
    .shift_en           (shift_en),
    .negate             (negate),
    .multiplicand_output(mo2),
    .addend_output      (ad2),
    .shift_count        (cnt2),
    .done               (dn2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] v, input logic sm);
    in_valid    = 1'b1;
    mi          = v;
    signed_mode = sm;
    tick();
    in_valid    = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; signed_mode = 1'b0;
    shift_en = 1'b0; negate = 1'b0; mi = '0;

    // Reset
    tick(); tick();
    chk("rst_reg", mo, 32'h0000);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_ready", rdy, 32'd1);
    chk("rst_done", dn, 32'd0);
    rst = 1'b1;

    // Full unsigned run
    load(8'h05, 1'b0);
    chk("load05_reg", mo, 32'h0005);
    chk("load05_ready", rdy, 32'd0);
    chk("load05_cnt", cnt, 32'd0);
    shift_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("run_reg", mo, 32'h0005 << i);
      chk("run_cnt", cnt, i);
      if (i < 8) chk("run_done_low", dn, 32'd0);
    end
    chk("run_done", dn, 32'd1);
    chk("run_ready", rdy, 32'd1);
    tick();
    chk("ninth_reg", mo, 32'h0500);
    chk("ninth_cnt", cnt, 32'd8);
    shift_en = 1'b0;

    // Signed load and negate (from DONE)
    load(8'hFB, 1'b1);
    chk("sload_reg", mo, 32'hFFFB);
    chk("sload_en0_reg", mo2, 32'h00FB);
    negate = 1'b1; #1;
    chk("sload_neg", ad, 32'h0005);
    negate = 1'b0; #1;
    chk("sload_pos", ad, 32'hFFFB);

    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_reg", mo, 32'h0000);
    chk("clr_ready", rdy, 32'd1);
    load(8'hFB, 1'b0);
    chk("uload_reg", mo, 32'h00FB);
    negate = 1'b1; #1;
    chk("uload_neg", ad, 32'hFF05);
    negate = 1'b0;
    // signed_mode after the load must not matter
    signed_mode = 1'b1; shift_en = 1'b1; tick(); shift_en = 1'b0;
    chk("late_sm_reg", mo, 32'h01F6);

    // Handshake
    clr = 1'b1; tick(); clr = 1'b0;
    load(8'h11, 1'b0);
    chk("hs_load", mo, 32'h0011);
    in_valid = 1'b1; mi = 8'h22; tick();
    chk("hs_active_ignore", mo, 32'h0011);
    shift_en = 1'b1; tick(); in_valid = 1'b0;
    chk("hs_active_shift", mo, 32'h0022);
    for (int i = 0; i < 7; i++) tick();
    chk("hs_done_reg", mo, 32'h1100);
    chk("hs_done", dn, 32'd1);
    in_valid = 1'b1; mi = 8'h22; tick(); in_valid = 1'b0; shift_en = 1'b0;
    chk("hs_reload_reg", mo, 32'h0022);
    chk("hs_reload_cnt", cnt, 32'd0);
    chk("hs_reload_done", dn, 32'd0);
    chk("hs_reload_ready", rdy, 32'd0);

    // Reset mid-operation
    clr = 1'b1; tick(); clr = 1'b0;
    load(8'h81, 1'b0);
    shift_en = 1'b1; tick(); tick(); tick(); shift_en = 1'b0;
    chk("mid_reg", mo, 32'h0408);
    chk("mid_cnt", cnt, 32'd3);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("midrst_reg", mo, 32'h0000);
    chk("midrst_cnt", cnt, 32'd0);
    chk("midrst_ready", rdy, 32'd1);
    chk("midrst_done", dn, 32'd0);

    // Clear mid-operation, with shift_en also asserted
    load(8'h81, 1'b0);
    shift_en = 1'b1; tick(); tick(); tick();
    chk("mid2_reg", mo, 32'h0408);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("midclr_reg", mo, 32'h0000);
    chk("midclr_cnt", cnt, 32'd0);
    chk("midclr_ready", rdy, 32'd1);
    // shift_en in IDLE is ignored
    tick(); shift_en = 1'b0;
    chk("idle_shift_reg", mo, 32'h0000);
    chk("idle_shift_cnt", cnt, 32'd0);

    // Negate wrap
    load(8'h80, 1'b1);
    chk("wrap_load", mo, 32'hFF80);
    shift_en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    shift_en = 1'b0;
    chk("wrap_reg", mo, 32'hC000);
    chk("wrap_cnt", cnt, 32'd7);
    negate = 1'b1; #1;
    chk("wrap_neg", ad, 32'h4000);
    shift_en = 1'b1; tick(); shift_en = 1'b0;
    chk("wrap_min_neg", ad, 32'h8000);
    chk("wrap_min_done", dn, 32'd1);
    load(8'h00, 1'b0);
    chk("zero_neg", ad, 32'h0000);
    negate = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
